// File: rtl/data_mem_ctrl.sv
// Handshaked byte-addressable data memory: byte/half/word loads and stores,
// fixed read latency, one outstanding access, error responses for bad accesses.
module data_mem_ctrl #(
  parameter int unsigned DEPTH_BYTES = 4096,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  resp_err_code
);

  localparam int unsigned WORDS = DEPTH_BYTES / 4;
  localparam int unsigned AW    = $clog2(DEPTH_BYTES);
  localparam int unsigned IW    = AW - 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_SIZE  = 2'b11;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  if (DEPTH_BYTES < 16 || (DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0) begin : g_bad_depth
    $error("data_mem_ctrl: DEPTH_BYTES must be a power of two >= 16");
  end
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_mem_ctrl: LATENCY must be in 1..15");
  end
  if ((ADDR_BASE & 32'(DEPTH_BYTES - 1)) != 32'h0) begin : g_bad_base
    $error("data_mem_ctrl: ADDR_BASE must be DEPTH_BYTES-aligned");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [31:0] mem [WORDS];

  logic        accept;
  logic [31:0] offset;
  logic [IW-1:0] word_idx;
  logic [1:0]  lane;
  logic [1:0]  err_code;
  logic        is_err;
  logic [3:0]  be;
  logic [31:0] wdata_steer;
  logic [31:0] rd_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] rdata_d;

  assign req_ready  = (state_q == IDLE) || ((state_q == RESP) && resp_ready);
  assign resp_valid = (state_q == RESP);
  assign accept     = req_valid && req_ready;

  // ADDR_BASE is DEPTH-aligned, so the offset's low bits equal the address lane
  assign offset   = req_addr - ADDR_BASE;
  assign word_idx = offset[AW-1:2];
  assign lane     = req_addr[1:0];

  always_comb begin
    err_code = ERR_NONE;
    if (req_size == ERR_SIZE) begin
      err_code = ERR_SIZE;
    end else if (offset >= 32'(DEPTH_BYTES)) begin
      err_code = ERR_RANGE;
    end else if ((req_size == SZ_HALF && lane[0]) ||
                 (req_size == SZ_WORD && lane != 2'b00)) begin
      err_code = ERR_ALIGN;
    end
  end

  assign is_err = (err_code != ERR_NONE);

  always_comb begin
    be          = '0;
    wdata_steer = '0;
    case (req_size)
      SZ_BYTE: begin
        be[lane]    = 1'b1;
        wdata_steer = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        be          = lane[1] ? 4'b1100 : 4'b0011;
        wdata_steer = {2{req_wdata[15:0]}};
      end
      SZ_WORD: begin
        be          = 4'b1111;
        wdata_steer = req_wdata;
      end
      default: begin
        be          = '0;
        wdata_steer = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !is_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[word_idx][b*8 +: 8] <= wdata_steer[b*8 +: 8];
        end
      end
    end
  end

  assign rd_word  = mem[word_idx];
  assign byte_sel = rd_word[{lane, 3'b000} +: 8];
  assign half_sel = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_data = '0;
    case (req_size)
      SZ_BYTE: load_data = req_unsigned ? {24'h0, byte_sel}
                                        : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = req_unsigned ? {16'h0, half_sel}
                                        : {{16{half_sel[15]}}, half_sel};
      SZ_WORD: load_data = rd_word;
      default: load_data = '0;
    endcase
  end

  assign rdata_d = (req_we || is_err) ? '0 : load_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
      resp_err_code <= ERR_NONE;
    end else if (accept) begin
      resp_rdata    <= rdata_d;
      resp_err      <= is_err;
      resp_err_code <= err_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // An accept from RESP (same-cycle handshake) takes the same path as from IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (LATENCY > 1) ? WAIT : RESP;
          cnt_d   = (LATENCY > 1) ? 4'd1 : 4'd0;
        end
      end
      WAIT: begin
        if (cnt_q >= LAT_M1) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          if (accept) begin
            state_d = (LATENCY > 1) ? WAIT : RESP;
            cnt_d   = (LATENCY > 1) ? 4'd1 : 4'd0;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule
